// File: rtl/pc_control_if.sv
// pc_control_if
//   Groups the control, operand and result signals between the opcode decoder or
//   datapath and the program-counter / branch-resolution unit.
//   master : decoder/datapath side. It drives branch_en, branch, hlt, instr, rs_data,
//            flag_we and alu_flags, and it receives pc, pc_plus2, taken, halted and flags.
//   slave  : pc_control side. The directions are the reverse of the master.
interface pc_control_if #(
  parameter int WIDTH = 16
);
  logic             branch_en;
  logic             branch;
  logic             hlt;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] rs_data;
  logic [2:0]       flag_we;
  logic [2:0]       alu_flags;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus2;
  logic             taken;
  logic             halted;
  logic [2:0]       flags;

  modport master (
    output branch_en, branch, hlt, instr, rs_data, flag_we, alu_flags,
    input  pc, pc_plus2, taken, halted, flags
  );

  modport slave (
    input  branch_en, branch, hlt, instr, rs_data, flag_we, alu_flags,
    output pc, pc_plus2, taken, halted, flags
  );
endinterface

// File: rtl/pc_control.sv
// pc_control
//   Program counter and branch resolution for the single-cycle core. The module holds
//   the PC, the {N,Z,V} flag register and the run/halt state.
//   clk : core clock. All state updates on the rising edge.
//   rst : asynchronous, active-high reset. It sets pc=RESET_PC, flags=0 and state=RUN.
//   bus : pc_control_if.slave. The inputs are the decoder controls, instr, rs_data and
//         the ALU flag writes. The outputs are pc, pc_plus2, taken, halted and flags.
module pc_control #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  pc_control_if.slave  bus
);

  localparam int IMM_W = 9;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       flags_wr;

  logic             flag_n, flag_z, flag_v;
  logic             cond_true;
  logic             taken;
  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] imm_offset;
  logic [WIDTH-1:0] br_target;

  // Opcode bits above the condition field and bit 0 of the register target play no part here.
  logic unused_bits;
  assign unused_bits = ^{bus.instr[WIDTH-1:12], bus.rs_data[0]};

  assign flag_n = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_v = flags_q[0];

  // Conditions use the flags registered before this edge. A flag write in the same
  // cycle does not affect the branch decision in that cycle.
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.instr[11:9])
      3'b000: cond_true = ~flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = ~flag_z & ~flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z | ~flag_n;   // Z=1 | (Z=0 & N=0)
      3'b101: cond_true = flag_n | flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
    endcase
  end

  assign taken      = bus.branch_en & cond_true & (state_q == ST_RUN);
  assign pc_plus2   = pc_q + WIDTH'(2);
  // Sign-extended imm9, scaled to a halfword offset. The extra LSB is the <<1.
  assign imm_offset = {{(WIDTH-IMM_W-1){bus.instr[IMM_W-1]}}, bus.instr[IMM_W-1:0], 1'b0};
  assign br_target  = {bus.rs_data[WIDTH-1:1], 1'b0};

  // Per-flag masked write. A bit with no write enable holds its value.
  for (genvar gi = 0; gi < 3; gi++) begin : g_flag_wr
    assign flags_wr[gi] = bus.flag_we[gi] ? bus.alu_flags[gi] : flags_q[gi];
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    if (state_q == ST_RUN) begin
      flags_d = flags_wr;
      // hlt has priority. If branch_en arrives with it, the branch is ignored.
      if (bus.hlt) begin
        state_d = ST_HALTED;
      end else if (taken && bus.branch) begin
        pc_d = br_target;
      end else if (taken) begin
        pc_d = pc_plus2 + imm_offset;
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus2 = pc_plus2;
  assign bus.taken    = taken;
  assign bus.halted   = (state_q == ST_HALTED);
  assign bus.flags    = flags_q;

endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control
//   Checks pc_control in three stages:
//   - a table of directed vectors with expected constants,
//   - hand-written reset and halt sequences,
//   - a random run compared against a behavioural reference model.
module tb_pc_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_control_if #(.WIDTH(16)) bus();

  pc_control #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [15:0] m_pc;
  logic [2:0]  m_flags;
  logic        m_halt;

  typedef struct {
    string       name;
    logic        be, br, h;
    logic [15:0] ins, rs;
    logic [2:0]  we, af;
    logic        exp_taken;
    logic [15:0] exp_pc;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic be, input logic br, input logic h,
                       input logic [15:0] ins, input logic [15:0] rs,
                       input logic [2:0] we, input logic [2:0] af);
    bus.branch_en = be;
    bus.branch    = br;
    bus.hlt       = h;
    bus.instr     = ins;
    bus.rs_data   = rs;
    bus.flag_we   = we;
    bus.alu_flags = af;
  endtask

  function automatic void add(input string name, input logic be, input logic br,
                              input logic [15:0] ins, input logic [15:0] rs,
                              input logic [2:0] we, input logic [2:0] af,
                              input logic tk, input logic [15:0] pc, input logic [2:0] fl);
    vec_t v;
    v.name = name; v.be = be; v.br = br; v.h = 1'b0; v.ins = ins; v.rs = rs;
    v.we = we; v.af = af; v.exp_taken = tk; v.exp_pc = pc; v.exp_flags = fl;
    tbl.push_back(v);
  endfunction

  // Branch condition taken from the condition table. f = {N,Z,V}.
  function automatic logic m_cond(input logic [2:0] ccc, input logic [2:0] f);
    logic n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (ccc)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  // Advances the model by one clock edge, using the inputs currently driven.
  task automatic model_step();
    int   nxt;
    int   off;
    logic tk;
    if (!m_halt) begin
      tk = bus.branch_en && m_cond(bus.instr[11:9], m_flags);
      nxt = int'(m_pc) + 2;
      if (bus.hlt) begin
        m_halt = 1'b1;
        nxt = int'(m_pc);
      end else if (tk && bus.branch) begin
        nxt = int'(bus.rs_data) - int'(bus.rs_data) % 2;
      end else if (tk) begin
        off = int'(bus.instr[8:0]);
        if (off >= 256) off = off - 512;
        nxt = int'(m_pc) + 2 + 2 * off;
      end
      m_pc = 16'(nxt & 32'hFFFF);
      for (int i = 0; i < 3; i++)
        if (bus.flag_we[i]) m_flags[i] = bus.alu_flags[i];
    end
  endtask

  // This task is called at edge+1 with the inputs already driven. It checks the
  // combinational outputs, then it clocks the DUT and checks the registered state.
  task automatic run_cycle(input string tag);
    logic exp_taken;
    #2;
    exp_taken = !m_halt && bus.branch_en && m_cond(bus.instr[11:9], m_flags);
    chk({tag, " taken"}, 32'(bus.taken), 32'(exp_taken));
    chk({tag, " pc_plus2"}, 32'(bus.pc_plus2), 32'(16'(m_pc + 16'd2)));
    model_step();
    @(posedge clk); #1;
    chk({tag, " pc"}, 32'(bus.pc), 32'(m_pc));
    chk({tag, " flags"}, 32'(bus.flags), 32'(m_flags));
    chk({tag, " halted"}, 32'(bus.halted), 32'(m_halt));
    $display("%s: be=%0b br=%0b hlt=%0b instr=%h rs=%h -> pc=%h flags=%b halted=%0b",
             tag, bus.branch_en, bus.branch, bus.hlt, bus.instr, bus.rs_data,
             bus.pc, bus.flags, bus.halted);
  endtask

  // Asserts reset mid-cycle and checks that it takes effect without a clock edge.
  // Reset is held across one edge, then released at edge+1.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, " rst pc"}, 32'(bus.pc), 32'h0);
    chk({tag, " rst flags"}, 32'(bus.flags), 32'h0);
    chk({tag, " rst halted"}, 32'(bus.halted), 32'h0);
    @(posedge clk); #1;
    chk({tag, " rst hold pc"}, 32'(bus.pc), 32'h0);
    rst = 1'b0;
    m_pc = 16'h0000; m_flags = 3'b000; m_halt = 1'b0;
    $display("%s: async reset applied, pc=%h", tag, bus.pc);
  endtask

  initial begin
    logic [15:0] pc_now;
    int          halt_cycles;

    drive(0, 0, 0, 16'h0, 16'h0, 3'b0, 3'b0);
    m_pc = 16'h0000; m_flags = 3'b000; m_halt = 1'b0;

    // Directed table. Every row starts from the state the previous row left behind.
    for (int i = 0; i < 10; i++)
      add("t2_step", 0, 0, 16'h0000, 16'h0000, 3'b000, 3'b000, 0, 16'(2 * (i + 1)), 3'b000);
    add("t2_br_fffe", 1, 1, 16'h0E00, 16'hFFFF, 3'b000, 3'b000, 1, 16'hFFFE, 3'b000);
    add("t2_wrap",    0, 0, 16'h0000, 16'h0000, 3'b000, 3'b000, 0, 16'h0000, 3'b000);
    add("t3_setz",    1, 1, 16'h0E00, 16'h0020, 3'b111, 3'b010, 1, 16'h0020, 3'b010);
    add("t3_b_eq",    1, 0, 16'h03FC, 16'h0000, 3'b000, 3'b000, 1, 16'h001A, 3'b010);
    add("t3_br_odd",  1, 1, 16'h0E00, 16'h0021, 3'b000, 3'b000, 1, 16'h0020, 3'b010);
    add("t3_b_ne",    1, 0, 16'h01FC, 16'h0000, 3'b000, 3'b000, 0, 16'h0022, 3'b010);
    add("t4_br_al",   1, 1, 16'h0E00, 16'h1235, 3'b000, 3'b000, 1, 16'h1234, 3'b010);
    add("t4_br_ov",   1, 1, 16'h0C00, 16'h5555, 3'b000, 3'b000, 0, 16'h1236, 3'b010);
    add("t5_clr",     0, 0, 16'h0000, 16'h0000, 3'b111, 3'b000, 0, 16'h1238, 3'b000);
    add("t5_b_eq_wr", 1, 0, 16'h0204, 16'h0000, 3'b010, 3'b010, 0, 16'h123A, 3'b010);
    add("t5_after",   0, 0, 16'h0000, 16'h0000, 3'b000, 3'b000, 0, 16'h123C, 3'b010);
    add("setn",       0, 0, 16'h0000, 16'h0000, 3'b100, 3'b100, 0, 16'h123E, 3'b110);
    add("b_le",       1, 0, 16'h0A10, 16'h0000, 3'b000, 3'b000, 1, 16'h1260, 3'b110);
    add("b_gt",       1, 0, 16'h0410, 16'h0000, 3'b000, 3'b000, 0, 16'h1262, 3'b110);
    add("b_lt",       1, 0, 16'h0610, 16'h0000, 3'b000, 3'b000, 1, 16'h1284, 3'b110);
    add("b_ge",       1, 0, 16'h0810, 16'h0000, 3'b000, 3'b000, 1, 16'h12A6, 3'b110);
    add("br_low",     1, 1, 16'h0E00, 16'h0002, 3'b000, 3'b000, 1, 16'h0002, 3'b110);
    add("b_neg_wrap", 1, 0, 16'h0FFC, 16'h0000, 3'b000, 3'b000, 1, 16'hFFFC, 3'b110);
    add("no_be",      0, 0, 16'h0E00, 16'h0000, 3'b000, 3'b000, 0, 16'hFFFE, 3'b110);

    #12;
    chk("reset pc", 32'(bus.pc), 32'h0);
    chk("reset flags", 32'(bus.flags), 32'h0);
    chk("reset halted", 32'(bus.halted), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    pc_now = 16'h0000;
    foreach (tbl[k]) begin
      drive(tbl[k].be, tbl[k].br, tbl[k].h, tbl[k].ins, tbl[k].rs, tbl[k].we, tbl[k].af);
      #2;
      chk({tbl[k].name, " taken"}, 32'(bus.taken), 32'(tbl[k].exp_taken));
      chk({tbl[k].name, " pc_plus2"}, 32'(bus.pc_plus2), 32'(16'(pc_now + 16'd2)));
      @(posedge clk); #1;
      chk({tbl[k].name, " pc"}, 32'(bus.pc), 32'(tbl[k].exp_pc));
      chk({tbl[k].name, " flags"}, 32'(bus.flags), 32'(tbl[k].exp_flags));
      chk({tbl[k].name, " halted"}, 32'(bus.halted), 32'h0);
      $display("%s: pc=%h flags=%b taken_exp=%0b", tbl[k].name, bus.pc, bus.flags,
               tbl[k].exp_taken);
      pc_now = tbl[k].exp_pc;
    end
    m_pc = pc_now; m_flags = 3'b110; m_halt = 1'b0;

    // T1: asynchronous reset mid-run with pc=0x0040 and all flags set.
    drive(1, 1, 0, 16'h0E00, 16'h0040, 3'b111, 3'b111);
    run_cycle("t1_goto40");
    chk("t1 pc 0040", 32'(bus.pc), 32'h0040);
    drive(0, 0, 0, 16'h0, 16'h0, 3'b0, 3'b0);
    async_reset("t1");
    run_cycle("t1_after");

    // T6: HLT at 0x0030, then 5 cycles of ignored stimulus, then reset back to RUN.
    drive(1, 1, 0, 16'h0E00, 16'h0030, 3'b000, 3'b000);
    run_cycle("t6_goto30");
    drive(0, 0, 1, 16'h0, 16'h0, 3'b000, 3'b000);
    run_cycle("t6_hlt");
    chk("t6 pc held", 32'(bus.pc), 32'h0030);
    chk("t6 halted", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'($urandom), 1'($urandom), 16'h0E00, 16'($urandom), 3'b111, 3'($urandom));
      run_cycle("t6_frozen");
      chk("t6 frozen pc", 32'(bus.pc), 32'h0030);
    end
    drive(0, 0, 0, 16'h0, 16'h0, 3'b0, 3'b0);
    async_reset("t6");
    run_cycle("t6_run");
    chk("t6 run pc", 32'(bus.pc), 32'h0002);

    // Both branch_en and hlt are asserted. hlt wins.
    drive(1, 1, 1, 16'h0E00, 16'h4444, 3'b000, 3'b000);
    run_cycle("both_hlt_br");
    async_reset("both");

    // Randomized run compared against the reference model.
    halt_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0),
            16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
      run_cycle("rand");
      if (m_halt) halt_cycles++;
      if (halt_cycles > 3) begin
        halt_cycles = 0;
        async_reset("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
